// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver and the companion transmitter:
// state encoding, data width, default clock/baud and bit-period helper.
// Optional even-parity framing is enabled by the macro RS232_RX_PARITY_EN.
package rs232_pkg;

    localparam int DATA_W        = 8;
    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115200;

    // state        | meaning
    // ST_IDLE      | line idle, waiting for a falling edge
    // ST_START     | timing to mid start bit to reject glitches
    // ST_DATA      | sampling 8 data bits, LSB first
    // ST_PARITY    | sampling the even-parity bit (parity build only)
    // ST_STOP      | sampling the stop bit, then reporting the byte
    // ST_WAIT_IDLE | bad stop bit seen, waiting for the line to go high
`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
    } rs232_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
    } rs232_state_t;
`endif

    // Clock cycles per serial bit (integer division).
    function automatic int calc_bit_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
// master = line driver / byte consumer, slave = the receiver itself.
interface rs232_rx_if;
    import rs232_pkg::*;

    logic              i_rx_pin;
    logic [DATA_W-1:0] o_rx_dat;
    logic              o_rx_done;
    logic              o_rx_frame_err;
    logic              o_rx_busy;

    modport master (
        output i_rx_pin,
        input  o_rx_dat, o_rx_done, o_rx_frame_err, o_rx_busy
    );

    modport slave (
        input  i_rx_pin,
        output o_rx_dat, o_rx_done, o_rx_frame_err, o_rx_busy
    );

endinterface

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle level (1).
module rs232_sync (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic rx_pin,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the line and keep one cycle of history for edge detection.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/rs232_rx.sv
// RS-232 receiver, 8N1 by default; with RS232_RX_PARITY_EN defined the frame
// carries one even-parity bit after bit 7 (8E1). Bits are sampled at their
// midpoint; the FSM returns to idle at mid stop bit so zero-gap frames work.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic      clk_ref,
    input  logic      rst_n,
    rs232_rx_if.slave rx
);

    localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    logic rx_sync;
    logic rx_fall;

    rs232_sync u_sync (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .rx_pin  (rx.i_rx_pin),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    rs232_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] dat_q;
    logic              done_q;
    logic              err_q;
    logic              busy_q;
`ifdef RS232_RX_PARITY_EN
    logic              par_err_q;
`endif

    // Frame FSM with baud counter, shift register and registered outputs.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state  <= ST_START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_W'(HALF_CNT - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_sync) begin
                            state <= ST_DATA;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_W'(BIT_CNT - 1)) begin
                        cnt     <= '0;
                        shift_q <= {rx_sync, shift_q[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef RS232_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_W'(BIT_CNT - 1)) begin
                        cnt       <= '0;
                        par_err_q <= rx_sync ^ (^shift_q);
                        state     <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_W'(BIT_CNT - 1)) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            err_q <= 1'b1;
                            state <= ST_WAIT_IDLE;
`ifdef RS232_RX_PARITY_EN
                        end else if (par_err_q) begin
                            err_q  <= 1'b1;
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
`endif
                        end else begin
                            dat_q  <= shift_q;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.o_rx_dat       = dat_q;
    assign rx.o_rx_done      = done_q;
    assign rx.o_rx_frame_err = err_q;
    assign rx.o_rx_busy      = busy_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx at 50 MHz / 115200 baud. A monitor logs
// every o_rx_done byte; scenario tasks push expected bytes and compare.
module tb_rs232_rx;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;
`ifdef RS232_RX_PARITY_EN
    localparam int EXP_LAT   = 4126 + BIT;
`else
    localparam int EXP_LAT   = 4126;
`endif

    logic clk;
    logic rst_n;
    int   cyc;

    rs232_rx_if rx_if ();

    rs232_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk_ref (clk),
        .rst_n   (rst_n),
        .rx      (rx_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         done_cnt;
    int         err_cnt;
    int         overlap_cnt;
    int         width_viol;
    int         last_done_cyc;
    logic       prev_done;
`ifdef RS232_RX_PARITY_EN
    logic       par_flip;
`endif

    // Monitor: log output pulses and pulse-shape violations.
    always @(negedge clk) begin
        if (rx_if.o_rx_done === 1'b1) begin
            done_cnt++;
            obs_q.push_back(rx_if.o_rx_dat);
            last_done_cyc = cyc;
            if (prev_done === 1'b1) width_viol++;
        end
        if (rx_if.o_rx_frame_err === 1'b1) err_cnt++;
        if (rx_if.o_rx_done === 1'b1 && rx_if.o_rx_frame_err === 1'b1) overlap_cnt++;
        prev_done = rx_if.o_rx_done;
    end

    task automatic send_bit(input logic b);
        rx_if.i_rx_pin = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RS232_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        n_checks++;
        if (rx_if.o_rx_dat !== 8'h00) begin
            n_fail++; $display("FAIL reset_dat: got %h want 00", rx_if.o_rx_dat);
        end
        n_checks++;
        if (rx_if.o_rx_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", rx_if.o_rx_done);
        end
        n_checks++;
        if (rx_if.o_rx_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", rx_if.o_rx_frame_err);
        end
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", rx_if.o_rx_busy);
        end
    endtask

    task automatic test_single_byte();
        int d0, e0, t0, lat;
        logic [7:0] e, o;
        d0 = done_cnt; e0 = err_cnt; t0 = cyc;
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        repeat (20) @(negedge clk);
        lat = last_done_cyc - t0;
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL aa_done_count: got %0d want 1", done_cnt - d0);
        end
        n_checks++;
        if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
            n_fail++; $display("FAIL aa_latency: got %0d want %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (err_cnt != e0) begin
            n_fail++; $display("FAIL aa_no_err: got %0d want 0", err_cnt - e0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL aa_data: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_cnt;
        rx_if.i_rx_pin = 1'b0;
        repeat (5) @(negedge clk);
        rx_if.i_rx_pin = 1'b1;
        repeat (15) @(negedge clk);
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL glitch_busy_high: got %b want 1", rx_if.o_rx_busy);
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL glitch_busy_low: got %b want 0", rx_if.o_rx_busy);
        end
        repeat (BIT * 10) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++; $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0);
        end
    endtask

    task automatic test_frame_err();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hB8, 1'b0);
        repeat (BIT * 2) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d want 1", err_cnt - e0);
        end
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++; $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0);
        end
        n_checks++;
        if (rx_if.o_rx_dat !== 8'hAA) begin
            n_fail++; $display("FAIL ferr_dat_kept: got %h want aa", rx_if.o_rx_dat);
        end
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL ferr_wait_busy: got %b want 1", rx_if.o_rx_busy);
        end
        rx_if.i_rx_pin = 1'b1;
        repeat (BIT) @(negedge clk);
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL ferr_idle_busy: got %b want 0", rx_if.o_rx_busy);
        end
        n_checks++;
        if (err_cnt - e0 != 1) begin
            n_fail++; $display("FAIL ferr_single: got %0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [7:0] e, o;
        d0 = done_cnt;
        exp_q.push_back(8'hB8);
        send_frame(8'hB8, 1'b1);
        exp_q.push_back(8'h3B);
        send_frame(8'h3B, 1'b1);
        rx_if.i_rx_pin = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL b2b_data: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        logic [7:0] part, e, o;
        part = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(part[i]);
        rx_if.i_rx_pin = part[4];
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rx_if.i_rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (BIT * 12) @(negedge clk);
        n_checks++;
        if (rx_if.o_rx_busy !== 1'b0 || done_cnt != d0) begin
            n_fail++; $display("FAIL rst_discard: got busy %b dones %0d want 0 0",
                               rx_if.o_rx_busy, done_cnt - d0);
        end
        exp_q.push_back(8'h3B);
        send_frame(8'h3B, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL rst_done_count: got %0d want 1", done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL rst_data: got %h want %h", o, e);
            end
        end
    endtask

`ifdef RS232_RX_PARITY_EN
    task automatic test_parity();
        int d0, e0;
        logic [7:0] e, o;
        d0 = done_cnt; e0 = err_cnt;
        par_flip = 1'b1;
        send_frame(8'h3B, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            n_fail++; $display("FAIL par_bad: got errs %0d dones %0d want 1 0",
                               err_cnt - e0, done_cnt - d0);
        end
        par_flip = 1'b0;
        exp_q.push_back(8'h3B);
        send_frame(8'h3B, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 1) begin
            n_fail++; $display("FAIL par_good: got dones %0d errs %0d want 1 1",
                               done_cnt - d0, err_cnt - e0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL par_data: got %h want %h", o, e);
            end
        end
    endtask
`endif

    task automatic test_final();
        n_checks++;
        if (overlap_cnt != 0) begin
            n_fail++; $display("FAIL done_err_overlap: got %0d want 0", overlap_cnt);
        end
        n_checks++;
        if (width_viol != 0) begin
            n_fail++; $display("FAIL done_width: got %0d long pulses want 0", width_viol);
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL extra_bytes: got %0d want 0", obs_q.size());
        end
    endtask

    // Watchdog: the sequence needs well under this many cycles.
    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        done_cnt = 0; err_cnt = 0; overlap_cnt = 0; width_viol = 0;
        last_done_cyc = 0; prev_done = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        rx_if.i_rx_pin = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef RS232_RX_PARITY_EN
        test_parity();
`endif
        test_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
